// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: configuration sequencer for one PWM unit.
// Accepts period/duty requests, applies the period on a PWM period boundary,
// then slews the duty toward its target one step every N PWM periods.
module pwm_ramp_ctrl #(
   parameter int unsigned CNT_WIDTH  = 16,
   parameter int unsigned STEP_WIDTH = 8,
   parameter int unsigned DIV_WIDTH  = 8,
   parameter int unsigned RST_PERIOD = 1000
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [CNT_WIDTH-1:0]  req_period_i,
   input  logic [CNT_WIDTH-1:0]  req_duty_i,
   input  logic [STEP_WIDTH-1:0] req_step_i,
   input  logic [DIV_WIDTH-1:0]  req_div_i,
   output logic [CNT_WIDTH-1:0]  cfg_period_o,
   output logic [CNT_WIDTH-1:0]  cfg_duty_o,
   output logic                  period_tick_o,
   output logic                  busy_o,
   output logic                  done_o
);

   // Wide enough that duty +/- step and |target - duty| never wrap.
   localparam int unsigned AW  = CNT_WIDTH + 1;
   localparam int unsigned MW  = (AW > STEP_WIDTH) ? AW : STEP_WIDTH;
   localparam int unsigned DW1 = DIV_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RAMP = 2'd2
   } state_e;

   state_e                state;
   logic [CNT_WIDTH-1:0]  pcnt;
   logic [CNT_WIDTH-1:0]  period_lat;
   logic [CNT_WIDTH-1:0]  target;
   logic [STEP_WIDTH-1:0] step_lat;
   logic [DIV_WIDTH-1:0]  div_lat;
   logic [DIV_WIDTH-1:0]  dcnt;

   logic [CNT_WIDTH-1:0]  req_period_eff;
   logic [CNT_WIDTH-1:0]  req_target;
   logic [DIV_WIDTH-1:0]  div_eff;
   logic                  div_hit;
   logic [MW-1:0]         duty_x;
   logic [MW-1:0]         tgt_x;
   logic [MW-1:0]         step_x;
   logic [MW-1:0]         diff_x;
   logic [MW-1:0]         stepped_x;
   logic                  go_up;
   logic                  near;
   logic [CNT_WIDTH-1:0]  step_duty;

   // Handshake/status and the end-of-period strobe mirrored from the PWM counter.
   assign req_ready_o   = enable_i & (state == ST_IDLE);
   assign busy_o        = (state != ST_IDLE);
   assign period_tick_o = (pcnt >= (cfg_period_o - CNT_WIDTH'(1)));

   // Request normalisation: period 0 becomes 1, duty clamps to the period (100%).
   always_comb begin
      req_period_eff = req_period_i;
      if (req_period_i == '0) begin
         req_period_eff = CNT_WIDTH'(1);
      end
      req_target = req_duty_i;
      if (req_duty_i > req_period_eff) begin
         req_target = req_period_eff;
      end
   end

   // Divider: a step is due when this tick completes max(div,1) periods.
   always_comb begin
      div_eff = div_lat;
      if (div_lat == '0) begin
         div_eff = DIV_WIDTH'(1);
      end
      div_hit = ((DW1'(dcnt) + DW1'(1)) >= DW1'(div_eff));
   end

   // Next duty value: jump to target when close enough or step is 0, else move by step.
   always_comb begin
      duty_x    = MW'(cfg_duty_o);
      tgt_x     = MW'(target);
      step_x    = MW'(step_lat);
      go_up     = (tgt_x > duty_x);
      diff_x    = go_up ? (tgt_x - duty_x) : (duty_x - tgt_x);
      near      = (step_lat == '0) || (diff_x <= step_x);
      stepped_x = go_up ? (duty_x + step_x) : (duty_x - step_x);
      step_duty = near ? target : CNT_WIDTH'(stepped_x);
   end

   // Sequencer state, period mirror counter and registered config outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= ST_IDLE;
         pcnt         <= '0;
         cfg_period_o <= CNT_WIDTH'(RST_PERIOD);
         cfg_duty_o   <= '0;
         period_lat   <= '0;
         target       <= '0;
         step_lat     <= '0;
         div_lat      <= '0;
         dcnt         <= '0;
         done_o       <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (period_tick_o) begin
            pcnt <= '0;
         end else begin
            pcnt <= pcnt + CNT_WIDTH'(1);
         end

         if (!enable_i) begin
            // Abort: drop the request, force duty off, keep the running period.
            state      <= ST_IDLE;
            cfg_duty_o <= '0;
            dcnt       <= '0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (req_valid_i) begin
                     period_lat <= req_period_eff;
                     target     <= req_target;
                     step_lat   <= req_step_i;
                     div_lat    <= req_div_i;
                     state      <= ST_SYNC;
                  end
               end
               ST_SYNC: begin
                  if (period_tick_o) begin
                     cfg_period_o <= period_lat;
                     dcnt         <= '0;
                     state        <= ST_RAMP;
                  end
               end
               ST_RAMP: begin
                  if (period_tick_o) begin
                     if (div_hit) begin
                        dcnt       <= '0;
                        cfg_duty_o <= step_duty;
                        if (near) begin
                           done_o <= 1'b1;
                           state  <= ST_IDLE;
                        end
                     end else begin
                        dcnt <= dcnt + DIV_WIDTH'(1);
                     end
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
